// File: rtl/hub75_pkg.sv
// Shared definitions for the HUB75 pixel path.
//   - Panel geometry (columns, rows) and the address widths derived from it.
//   - Pixel width: one bit per colour channel, packed {R,G,B}.
//   - Write-side FSM state encoding used by the framebuffer.
package hub75_pkg;

    localparam int unsigned HUB75_COLS   = 32;
    localparam int unsigned HUB75_ROWS   = 64;
    localparam int unsigned HUB75_COL_W  = $clog2(HUB75_COLS);
    localparam int unsigned HUB75_LINE_W = $clog2(HUB75_ROWS / 2);
    localparam int unsigned HUB75_RGB_W  = 3;

    typedef enum logic [0:0] {
        StFill,
        StWaitSwap
    } wr_state_e;

endpackage

// File: rtl/hub75_fb_ram.sv
// Simple dual-port pixel RAM: one synchronous write port, one synchronous read port.
// Read-before-write: a read and write of the same address on the same edge returns
// the old word. No reset on the array or the read register so it maps onto block RAM.
//   clk      : clock
//   wr_en    : write strobe
//   wr_addr  : write address
//   wr_data  : {R,G,B} to store
//   rd_en    : read strobe; rd_data holds when low
//   rd_addr  : read address
//   rd_data  : registered read data, valid the cycle after rd_en
module hub75_fb_ram
    import hub75_pkg::*;
#(
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   wr_en,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [HUB75_RGB_W-1:0] wr_data,
    input  logic                   rd_en,
    input  logic [ADDR_W-1:0]      rd_addr,
    output logic [HUB75_RGB_W-1:0] rd_data
);

    logic [HUB75_RGB_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/hub75_framebuffer.sv
// 1-bit-per-colour framebuffer feeding the HUB75 scan driver.
// A producer streams pixels in raster order into the back bank; the driver reads the
// front bank by (line, column) and gets the upper and lower half-panel pixels at once.
// Banks swap only when the driver signals a frame boundary after a complete frame.
//
// Build option: define HUB75_FB_DOUBLE_BUFFER_EN for two banks with a swap handshake.
// Without it there is a single bank written in place, wr_ready is always 1 and
// frame_swapped marks the first frame_start after each completed frame.
//
// Ports:
//   clk, rst           : clock, asynchronous active-high reset
//   wr_valid/wr_ready  : pixel handshake; wr_sof restarts the frame at (0,0)
//   wr_rgb             : pixel {R,G,B}
//   frame_start        : driver frame-boundary strobe
//   rd_en, rd_line, rd_column : read request into the front bank
//   rd_r1/g1/b1        : pixel at (rd_line, rd_column)
//   rd_r2/g2/b2        : pixel at (rd_line + ROWS/2, rd_column)
//   frame_swapped      : one-cycle pulse on a bank swap
module hub75_framebuffer
    import hub75_pkg::*;
#(
    parameter int unsigned COLS = HUB75_COLS,
    parameter int unsigned ROWS = HUB75_ROWS
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic                      wr_sof,
    input  logic [HUB75_RGB_W-1:0]    wr_rgb,
    input  logic                      frame_start,
    input  logic                      rd_en,
    input  logic [$clog2(ROWS/2)-1:0] rd_line,
    input  logic [$clog2(COLS)-1:0]   rd_column,
    output logic                      rd_r1,
    output logic                      rd_g1,
    output logic                      rd_b1,
    output logic                      rd_r2,
    output logic                      rd_g2,
    output logic                      rd_b2,
    output logic                      frame_swapped
);

    localparam int unsigned COL_W  = $clog2(COLS);
    localparam int unsigned LINE_W = $clog2(ROWS / 2);
    localparam int unsigned ADDR_W = LINE_W + COL_W;
    localparam int unsigned DEPTH  = COLS * ROWS / 2;
`ifdef HUB75_FB_DOUBLE_BUFFER_EN
    localparam int unsigned NUM_BANKS = 2;
`else
    localparam int unsigned NUM_BANKS = 1;
`endif

    logic [COL_W-1:0]       x_q, px;
    logic [LINE_W:0]        y_q, py;
    logic                   accept, last, swap;
    logic                   frame_swapped_q, rd_valid_q;
    logic [NUM_BANKS-1:0]   bank_we;
    logic [ADDR_W-1:0]      wr_addr, rd_addr;
    logic [HUB75_RGB_W-1:0] upper_data [NUM_BANKS];
    logic [HUB75_RGB_W-1:0] lower_data [NUM_BANKS];
    logic [HUB75_RGB_W-1:0] hi_data, lo_data;

    // Position of the current beat; an accepted wr_sof beat lands at (0,0).
    always_comb begin
        px = wr_sof ? '0 : x_q;
        py = wr_sof ? '0 : y_q;
    end

    assign accept  = wr_valid & wr_ready;
    assign last    = (px == COL_W'(COLS - 1)) && (py == (LINE_W + 1)'(ROWS - 1));
    assign wr_addr = {py[LINE_W-1:0], px};
    assign rd_addr = {rd_line, rd_column};

    // Power-of-two geometry: x and y roll over to 0 on their own after the last pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
        end else if (accept) begin
            x_q <= px + COL_W'(1);
            y_q <= (px == COL_W'(COLS - 1)) ? py + (LINE_W + 1)'(1) : py;
        end
    end

`ifdef HUB75_FB_DOUBLE_BUFFER_EN
    wr_state_e state_q, state_d;
    logic      front_q, rd_sel_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StFill;
            front_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (swap) begin
                front_q <= ~front_q;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        wr_ready = 1'b0;
        swap     = 1'b0;
        unique case (state_q)
            StFill: begin
                wr_ready = 1'b1;
                if (wr_valid && last) begin
                    state_d = StWaitSwap;
                end
            end
            StWaitSwap: begin
                if (frame_start) begin
                    swap    = 1'b1;
                    state_d = StFill;
                end
            end
            default: state_d = StFill;
        endcase
    end

    // Writes always target the back bank.
    assign bank_we = {accept & ~front_q, accept & front_q};

    // Remember which bank each read came from so a read on the swap edge keeps the old one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_sel_q <= 1'b0;
        end else if (rd_en) begin
            rd_sel_q <= front_q;
        end
    end

    assign hi_data = upper_data[rd_sel_q];
    assign lo_data = lower_data[rd_sel_q];
`else
    logic done_q, done_d;

    assign wr_ready = 1'b1;
    assign swap     = frame_start & done_q;
    assign bank_we  = accept;

    // done_q: a frame has completed and no frame_start has consumed it yet.
    always_comb begin
        done_d = done_q;
        if (swap) begin
            done_d = 1'b0;
        end
        if (accept && last) begin
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q <= 1'b0;
        end else begin
            done_q <= done_d;
        end
    end

    assign hi_data = upper_data[0];
    assign lo_data = lower_data[0];
`endif

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        hub75_fb_ram #(
            .DEPTH  (DEPTH),
            .ADDR_W (ADDR_W)
        ) u_upper (
            .clk     (clk),
            .wr_en   (bank_we[b] & ~py[LINE_W]),
            .wr_addr (wr_addr),
            .wr_data (wr_rgb),
            .rd_en   (rd_en),
            .rd_addr (rd_addr),
            .rd_data (upper_data[b])
        );

        hub75_fb_ram #(
            .DEPTH  (DEPTH),
            .ADDR_W (ADDR_W)
        ) u_lower (
            .clk     (clk),
            .wr_en   (bank_we[b] & py[LINE_W]),
            .wr_addr (wr_addr),
            .wr_data (wr_rgb),
            .rd_en   (rd_en),
            .rd_addr (rd_addr),
            .rd_data (lower_data[b])
        );
    end

    // The RAM read registers have no reset; rd_valid_q forces the outputs to 0 from
    // reset until the first read completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid_q      <= 1'b0;
            frame_swapped_q <= 1'b0;
        end else begin
            frame_swapped_q <= swap;
            if (rd_en) begin
                rd_valid_q <= 1'b1;
            end
        end
    end

    always_comb begin
        {rd_r1, rd_g1, rd_b1} = rd_valid_q ? hi_data : '0;
        {rd_r2, rd_g2, rd_b2} = rd_valid_q ? lo_data : '0;
    end

    assign frame_swapped = frame_swapped_q;

endmodule
